hazard_pipe_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_detect.sv | 16 +
 rtl/hazard_pipe_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    MEM_WAIT   = 2'd3
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bubble/flush counter covers 1..3, wait counter covers up to 255 cycles.
  localparam int CNT_W  = 2;
  localparam int WAIT_W = 8;

  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;
  localparam int MWAIT_CNT_W = 32;

endpackage

// File: rtl/hazard_detect.sv
// Combinational producer/consumer register match; the same compare serves load-use and forwarding checks.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic       prod_valid,
  input  logic [4:0] prod_dest,
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       uses_src2,
  output logic       hit
);

  assign hit = prod_valid && (prod_dest != REG_ZERO) &&
               ((prod_dest == src1) || (uses_src2 && (prod_dest == src2)));

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Mealy pipeline sequencer: memory wait > taken branch > load-use, acting in the detection cycle.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_pipe_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_BUBBLES    = 1,
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic       id_uses_src2,
  input  logic       idex_mem_r_en,
  input  logic [4:0] idex_dest,
  input  logic       br_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write_en,
  output logic       ifid_write_en,
  output logic       ifid_flush,
  output logic       idex_write_en,
  output logic       idex_flush,
  output logic       pipe_freeze,
  output logic       mem_timeout,
  output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_events,
  output logic [MWAIT_CNT_W-1:0] mem_wait_cycles
`endif
);

  localparam logic [CNT_W-1:0]  LB_RELOAD = CNT_W'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0]  BR_RELOAD = CNT_W'(BR_FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] TO_LIMIT  = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_t       state_q, state_d, saved_state_q, saved_state_d, eff_state;
  logic [CNT_W-1:0]  cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, eff_cnt;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              load_use, mem_stall, abort;
  logic              pc_we, ifid_we, idex_we, ifid_fl, idex_fl, freeze;

  hazard_detect u_load_use (
    .prod_valid (idex_mem_r_en),
    .prod_dest  (idex_dest),
    .src1       (id_src1),
    .src2       (id_src2),
    .uses_src2  (id_uses_src2),
    .hit        (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;
    timeout_d     = timeout_q;
    eff_state     = state_q;
    eff_cnt       = cnt_q;
    abort         = 1'b0;
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    idex_we       = 1'b1;
    ifid_fl       = 1'b0;
    idex_fl       = 1'b0;
    freeze        = 1'b0;

    // Leaving MEM_WAIT resumes the interrupted sequence within the same cycle.
    if (state_q == MEM_WAIT) begin
      if (!mem_stall) begin
        eff_state = saved_state_q;
        eff_cnt   = saved_cnt_q;
      end else if (wait_q == TO_LIMIT) begin
        abort     = 1'b1;
        eff_state = RUN;
        eff_cnt   = '0;
        timeout_d = 1'b1;
      end
    end

    if (mem_stall && !abort) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      freeze  = 1'b1;
      if (state_q != MEM_WAIT) begin
        saved_state_d = state_q;
        saved_cnt_d   = cnt_q;
        state_d       = MEM_WAIT;
        wait_d        = WAIT_W'(1);
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end else begin
      wait_d = '0;
      if (br_taken) begin
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
        if (BR_FLUSH_CYCLES > 1) begin
          state_d = BR_FLUSH;
          cnt_d   = BR_RELOAD;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end else if (eff_state == BR_FLUSH) begin
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
        state_d = (eff_cnt == CNT_W'(1)) ? RUN : BR_FLUSH;
        cnt_d   = eff_cnt - CNT_W'(1);
      end else if (eff_state == LOAD_STALL) begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_fl = 1'b1;
        state_d = (eff_cnt == CNT_W'(1)) ? RUN : LOAD_STALL;
        cnt_d   = eff_cnt - CNT_W'(1);
      end else if (load_use) begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_fl = 1'b1;
        if (LOAD_BUBBLES > 1) begin
          state_d = LOAD_STALL;
          cnt_d   = LB_RELOAD;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      wait_q        <= '0;
      saved_state_q <= RUN;
      saved_cnt_q   <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      saved_state_q <= saved_state_d;
      saved_cnt_q   <= saved_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  // Under reset the pipe is held with NOPs loaded and nothing advancing.
  assign pc_write_en   = rst_n && pc_we;
  assign ifid_write_en = rst_n && ifid_we;
  assign idex_write_en = rst_n && idex_we;
  assign ifid_flush    = !rst_n || ifid_fl;
  assign idex_flush    = !rst_n || idex_fl;
  assign pipe_freeze   = rst_n && freeze;
  assign mem_timeout   = timeout_q;
  assign ctrl_state    = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic bubble_cyc, branch_acc;

  assign bubble_cyc = !pc_we && !freeze;
  assign branch_acc = br_taken && !freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles    <= '0;
      flush_events    <= '0;
      mem_wait_cycles <= '0;
    end else begin
      if (bubble_cyc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      if (branch_acc && (flush_events != '1))
        flush_events <= flush_events + FLUSH_CNT_W'(1);
      if (freeze && (mem_wait_cycles != '1))
        mem_wait_cycles <= mem_wait_cycles + MWAIT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: directed hazard scenarios plus random traffic against a remaining-cycles model.
module tb_hazard_pipe_ctrl;

  localparam int LB = 3;
  localparam int BR = 2;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] id_src1, id_src2, idex_dest;
  logic       id_uses_src2, idex_mem_r_en, br_taken, mem_req, mem_ready;
  logic       pc_write_en, ifid_write_en, ifid_flush, idex_write_en, idex_flush;
  logic       pipe_freeze, mem_timeout;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, mem_wait_cycles;
  logic [15:0] flush_events;
`endif

  always #5 clk = ~clk;

  hazard_pipe_ctrl #(
    .LOAD_BUBBLES    (LB),
    .BR_FLUSH_CYCLES (BR),
    .MEM_TIMEOUT     (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_uses_src2  (id_uses_src2),
    .idex_mem_r_en (idex_mem_r_en),
    .idex_dest     (idex_dest),
    .br_taken      (br_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_write_en   (pc_write_en),
    .ifid_write_en (ifid_write_en),
    .ifid_flush    (ifid_flush),
    .idex_write_en (idex_write_en),
    .idex_flush    (idex_flush),
    .pipe_freeze   (pipe_freeze),
    .mem_timeout   (mem_timeout),
    .ctrl_state    (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .mem_wait_cycles (mem_wait_cycles)
`endif
  );

  int n_vec = 0;
  int n_fail = 0;

  // Model: remaining bubble / flush cycles, memory-wait bookkeeping, perf tallies.
  int stall_left, flush_left, waited;
  bit in_wait, to_flag;
  int m_stall, m_flush, m_wait;
  int freeze_seen, bubble_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    stall_left = 0; flush_left = 0; waited = 0;
    in_wait = 0; to_flag = 0;
    m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  task automatic idle();
    id_src1 = 5'd0; id_src2 = 5'd0; id_uses_src2 = 1'b0;
    idex_mem_r_en = 1'b0; idex_dest = 5'd0;
    br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc_we"},   pc_write_en,   1'b0);
    chk({tag, "_ifid_we"}, ifid_write_en, 1'b0);
    chk({tag, "_idex_we"}, idex_write_en, 1'b0);
    chk({tag, "_ifid_fl"}, ifid_flush,    1'b1);
    chk({tag, "_idex_fl"}, idex_flush,    1'b1);
    chk({tag, "_freeze"},  pipe_freeze,   1'b0);
    chk({tag, "_state"},   ctrl_state,    2'd0);
    chk({tag, "_timeout"}, mem_timeout,   1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs({tag, "_async"});
    @(posedge clk);
    #1;
    chk_reset_outputs({tag, "_held"});
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: sample at negedge, compare, advance the model, step past posedge.
  task automatic cycle();
    bit lu, ms, abort;
    int kind;        // 0 normal, 1 bubble, 2 flush, 3 freeze
    int exp_state;
    logic [5:0] exp_o;
    @(negedge clk);
    lu = idex_mem_r_en && (idex_dest != 0) &&
         ((idex_dest == id_src1) || (id_uses_src2 && (idex_dest == id_src2)));
    ms = mem_req && !mem_ready;
    exp_state = in_wait ? 3 : (flush_left > 0) ? 2 : (stall_left > 0) ? 1 : 0;
    chk("state", ctrl_state, exp_state);
    chk("mem_timeout", mem_timeout, to_flag);

    abort = in_wait && ms && (waited == TO);
    if (in_wait && !ms) in_wait = 0;
    if (abort) begin
      to_flag = 1; in_wait = 0; stall_left = 0; flush_left = 0;
    end
    if (ms && !abort) begin
      kind = 3;
      if (!in_wait) begin in_wait = 1; waited = 1; end
      else waited++;
    end else if (br_taken) begin
      kind = 2; flush_left = BR - 1; stall_left = 0; m_flush++;
    end else if (flush_left > 0) begin
      kind = 2; flush_left--;
    end else if (stall_left > 0) begin
      kind = 1; stall_left--;
    end else if (lu) begin
      kind = 1; stall_left = LB - 1;
    end else begin
      kind = 0;
    end
    if (kind == 1) m_stall++;
    if (kind == 3) m_wait++;

    // {pc_we, ifid_we, idex_we, ifid_flush, idex_flush, freeze}
    case (kind)
      1:       exp_o = 6'b001010;
      2:       exp_o = 6'b111110;
      3:       exp_o = 6'b000001;
      default: exp_o = 6'b111000;
    endcase
    chk("ctrl_outputs",
        {pc_write_en, ifid_write_en, idex_write_en, ifid_flush, idex_flush, pipe_freeze},
        exp_o);
    freeze_seen += int'(pipe_freeze);
    bubble_seen += int'(!pc_write_en && !pipe_freeze);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    model_clear();
    #2;
    do_reset("por");
    cycle();
    chk("post_reset_pc_we", pc_write_en, 1'b1);

    // Load-use on src1: exactly LB bubble cycles.
    bubble_seen = 0;
    idex_mem_r_en = 1'b1; idex_dest = 5'd5; id_src1 = 5'd5;
    cycle();
    idle();
    repeat (LB + 1) cycle();
    chk("lu_bubbles", bubble_seen, LB);

    // Destination r0 never stalls.
    bubble_seen = 0;
    idex_mem_r_en = 1'b1; idex_dest = 5'd0; id_src1 = 5'd0;
    cycle();
    chk("r0_no_stall", bubble_seen, 0);

    // Second operand only counts when it is read.
    idle();
    idex_mem_r_en = 1'b1; idex_dest = 5'd7; id_src2 = 5'd7; id_uses_src2 = 1'b0;
    cycle();
    chk("rt_unused_no_stall", bubble_seen, 0);
    id_uses_src2 = 1'b1;
    cycle();
    chk("rt_used_stall", bubble_seen, 1);
    idle();
    repeat (LB) cycle();

    // Branch and load-use together: branch wins.
    idex_mem_r_en = 1'b1; idex_dest = 5'd3; id_src1 = 5'd3; br_taken = 1'b1;
    cycle();
    idle();
    repeat (BR + 1) cycle();

    // Memory wait interrupting a LOAD_STALL, then resume.
    idex_mem_r_en = 1'b1; idex_dest = 5'd9; id_src1 = 5'd9;
    cycle();
    idle();
    cycle();
    freeze_seen = 0; bubble_seen = 0;
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (4) cycle();
    chk("mw_freeze_cycles", freeze_seen, 4);
    mem_ready = 1'b1;
    cycle();
    idle();
    repeat (2) cycle();
    chk("mw_resumed_bubbles", bubble_seen, 1);

    // Random traffic with a mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      id_src1       = 5'($urandom_range(0, 3));
      id_src2       = 5'($urandom_range(0, 3));
      id_uses_src2  = 1'($urandom_range(0, 1));
      idex_mem_r_en = 1'($urandom_range(0, 1));
      idex_dest     = 5'($urandom_range(0, 3));
      br_taken      = ($urandom_range(0, 9) == 0);
      mem_req       = ($urandom_range(0, 4) == 0);
      mem_ready     = 1'($urandom_range(0, 1));
      if (i == 300) do_reset("mid");
      cycle();
    end

`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall", stall_cycles, m_stall);
    chk("perf_flush", flush_events, m_flush);
    chk("perf_wait",  mem_wait_cycles, m_wait);
`endif

    // Memory never ready: abort after TO frozen cycles, flag sticks.
    do_reset("pre_to");
    idle();
    cycle();
    freeze_seen = 0;
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (TO + 1) cycle();
    chk("to_freeze_cycles", freeze_seen, TO);
    idle();
    cycle();
    chk("to_flag_set", mem_timeout, 1'b1);
    chk("to_state_run", ctrl_state, 2'd0);
    repeat (5) cycle();
    chk("to_flag_sticky", mem_timeout, 1'b1);
    do_reset("clr_to");
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: observed no finish, expected finish before 200000");
  end

endmodule
